// File: rtl/ofdm_loopback_ctrl.sv
// Loopback sequencer for the DUC/DDC chain: latches a frame config, flushes the chains,
// streams one frame into the DUC and waits for the DDC to return it. Optional DRAIN watchdog: LOOPBACK_CTRL_TIMEOUT_EN.
`timescale 1ns/1ps

module ofdm_loopback_ctrl #(
    parameter int CNT_W          = 16,
    parameter int FLUSH_CYCLES   = 64,
    parameter int TIMEOUT_CYCLES = 2097152
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             start,
    input  logic [31:0]      cfg_dac_fc,
    input  logic [31:0]      cfg_adc_fc,
    input  logic [15:0]      cfg_interp,
    input  logic [15:0]      cfg_decim,
    input  logic [CNT_W-1:0] cfg_nfft,
    input  logic [CNT_W-1:0] cfg_cp_len,
    input  logic [7:0]       cfg_symbols,
    output logic [31:0]      DAC_Fc_scaled,
    output logic [31:0]      ADC_Fc_scaled,
    output logic [15:0]      Interp_ratio,
    output logic [15:0]      decimate_ratio,
    output logic             chain_aresetn,
    input  logic [31:0]      s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    output logic [31:0]      m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic [3:0]       m_axis_tkeep,
    input  logic             ddc_tvalid,
    input  logic             ddc_tready,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam int TOT_W = CNT_W + 9;
    localparam int FL_W  = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_FLUSH, S_STREAM, S_DRAIN, S_DONE
    } state_t;

    state_t state, state_next;

    logic [CNT_W:0]   len_sum;
    logic [TOT_W-1:0] total_calc;
    logic [TOT_W-1:0] total_q;
    logic [TOT_W-1:0] tx_cnt;
    logic [TOT_W-1:0] rx_cnt;
    logic [FL_W-1:0]  flush_cnt;
    logic             stream;
    logic             tx_fire;
    logic             tx_last;
    logic             rx_fire;
    logic             rx_full;
    logic             flush_last;
    logic             timeout_hit;

    // Full-width product: 8-bit symbols times (CNT_W+1)-bit symbol length never truncates.
    assign len_sum    = {1'b0, cfg_nfft} + {1'b0, cfg_cp_len};
    assign total_calc = TOT_W'(cfg_symbols) * TOT_W'(len_sum);

    assign stream     = (state == S_STREAM);
    assign tx_fire    = stream && s_axis_tvalid && m_axis_tready;
    assign tx_last    = (tx_cnt == total_q - TOT_W'(1));
    assign rx_fire    = (state == S_STREAM || state == S_DRAIN) && ddc_tvalid && ddc_tready;
    assign rx_full    = (rx_cnt == total_q);
    assign flush_last = (flush_cnt == FL_W'(FLUSH_CYCLES - 1));

    assign m_axis_tdata  = stream ? s_axis_tdata : 32'h0;
    assign m_axis_tvalid = stream && s_axis_tvalid;
    assign s_axis_tready = stream && m_axis_tready;
    assign m_axis_tlast  = stream && tx_last;
    assign m_axis_tkeep  = stream ? 4'hF : 4'h0;

`ifdef LOOPBACK_CTRL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] drain_cnt;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            drain_cnt <= '0;
        end else if (state != S_DRAIN) begin
            drain_cnt <= '0;
        end else begin
            drain_cnt <= drain_cnt + TO_W'(1);
        end
    end

    assign timeout_hit = (state == S_DRAIN) && (drain_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout_hit        = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start) state_next = (total_calc == '0) ? S_DONE : S_LOAD;
            S_LOAD:   state_next = S_FLUSH;
            S_FLUSH:  if (flush_last) state_next = S_STREAM;
            S_STREAM: if (tx_fire && tx_last) state_next = S_DRAIN;
            S_DRAIN:  if (rx_full || timeout_hit) state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Chain reset is registered from the next state, so it is low for exactly the FLUSH cycles
    // and rises together with STREAM entry.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= S_IDLE;
            chain_aresetn <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            flush_cnt     <= '0;
            tx_cnt        <= '0;
            rx_cnt        <= '0;
        end else begin
            state         <= state_next;
            chain_aresetn <= (state_next != S_FLUSH);
            busy          <= (state_next != S_IDLE);
            done          <= (state == S_DONE);
            if (state == S_LOAD) begin
                flush_cnt <= '0;
            end else if (state == S_FLUSH) begin
                flush_cnt <= flush_cnt + FL_W'(1);
            end
            if (state == S_FLUSH) begin
                tx_cnt <= '0;
                rx_cnt <= '0;
            end else begin
                if (tx_fire) tx_cnt <= tx_cnt + TOT_W'(1);
                if (rx_fire && !rx_full) rx_cnt <= rx_cnt + TOT_W'(1);
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            DAC_Fc_scaled  <= '0;
            ADC_Fc_scaled  <= '0;
            Interp_ratio   <= '0;
            decimate_ratio <= '0;
            total_q        <= '0;
            error          <= 1'b0;
        end else if (state == S_IDLE && start) begin
            DAC_Fc_scaled  <= cfg_dac_fc;
            ADC_Fc_scaled  <= cfg_adc_fc;
            Interp_ratio   <= cfg_interp;
            decimate_ratio <= cfg_decim;
            total_q        <= total_calc;
            error          <= (total_calc == '0);
        end else if (timeout_hit && !rx_full) begin
            error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ofdm_loopback_ctrl.sv
// Directed bench for ofdm_loopback_ctrl: scoreboard queue of expected DUC samples, loopback DDC echo model.
`timescale 1ns/1ps

module tb_ofdm_loopback_ctrl;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        start;
    logic [31:0] cfg_dac_fc, cfg_adc_fc;
    logic [15:0] cfg_interp, cfg_decim;
    logic [15:0] cfg_nfft, cfg_cp_len;
    logic [7:0]  cfg_symbols;
    logic [31:0] DAC_Fc_scaled, ADC_Fc_scaled;
    logic [15:0] Interp_ratio, decimate_ratio;
    logic        chain_aresetn;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid, s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [3:0]  m_axis_tkeep;
    logic        ddc_tvalid, ddc_tready;
    logic        busy, done, error;

    ofdm_loopback_ctrl #(.CNT_W(16), .FLUSH_CYCLES(64), .TIMEOUT_CYCLES(100)) dut (
        .aclk(aclk), .aresetn(aresetn), .start(start),
        .cfg_dac_fc(cfg_dac_fc), .cfg_adc_fc(cfg_adc_fc),
        .cfg_interp(cfg_interp), .cfg_decim(cfg_decim),
        .cfg_nfft(cfg_nfft), .cfg_cp_len(cfg_cp_len), .cfg_symbols(cfg_symbols),
        .DAC_Fc_scaled(DAC_Fc_scaled), .ADC_Fc_scaled(ADC_Fc_scaled),
        .Interp_ratio(Interp_ratio), .decimate_ratio(decimate_ratio),
        .chain_aresetn(chain_aresetn),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tkeep(m_axis_tkeep),
        .ddc_tvalid(ddc_tvalid), .ddc_tready(ddc_tready),
        .busy(busy), .done(done), .error(error)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    int   frame_total, beat_idx, src_idx, echo_pending, echoed, echo_limit;
    int   rel_cyc, first_accept, chain_low, done_cnt, done_cyc, last_beat_cyc, tvalid_seen;
    logic err_at_done;
    logic [31:0] data_base;
    bit   bp_mode, cfg_check;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Samples the DUT just before the rising edge; models the source, the scoreboard and the DDC echo.
    task automatic monitor();
        logic [31:0] exp_data;
        if (m_axis_tvalid === 1'b1) tvalid_seen++;
        if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
            if (first_accept < 0) first_accept = rel_cyc;
            checkOutput("beat_in_frame", (beat_idx < frame_total), 1'b1);
            if (exp_q.size() > 0) begin
                exp_data = exp_q.pop_front();
                checkOutput("tdata", m_axis_tdata, exp_data);
            end
            checkOutput("tlast", m_axis_tlast, (beat_idx == frame_total - 1));
            checkOutput("tkeep", m_axis_tkeep, 4'hF);
            beat_idx++;
            echo_pending++;
            last_beat_cyc = rel_cyc;
        end
        if (s_axis_tvalid === 1'b1 && s_axis_tready === 1'b1) src_idx++;
        if (ddc_tvalid && ddc_tready) begin
            echo_pending--;
            echoed++;
        end
        if (chain_aresetn === 1'b0) chain_low++;
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc    = rel_cyc;
            err_at_done = error;
        end
        if (cfg_check && rel_cyc == 0) begin
            checkOutput("dac_fc_before", DAC_Fc_scaled, 32'd0);
            checkOutput("interp_before", Interp_ratio, 16'd0);
        end
        if (cfg_check && rel_cyc == 1) begin
            checkOutput("dac_fc_latched", DAC_Fc_scaled, 32'd10737418);
            checkOutput("adc_fc_latched", ADC_Fc_scaled, 32'd21474836);
            checkOutput("interp_latched", Interp_ratio, 16'd40);
            checkOutput("decim_latched", decimate_ratio, 16'd40);
            checkOutput("busy_in_load", busy, 1'b1);
        end
    endtask

    task automatic drivePattern();
        start = 1'b0;
        if (bp_mode) begin
            m_axis_tready = rel_cyc[0];
            s_axis_tvalid = ((rel_cyc % 5) != 4);
        end else begin
            m_axis_tready = 1'b1;
            s_axis_tvalid = 1'b1;
        end
        s_axis_tdata = data_base + 32'(src_idx);
        ddc_tvalid   = (echo_pending > 0) && (echoed < echo_limit);
        ddc_tready   = 1'b1;
    endtask

    task automatic cycle();
        @(negedge aclk);
        monitor();
        @(posedge aclk);
        #1;
        rel_cyc++;
        drivePattern();
    endtask

    // Called just after a rising edge: loads config, fills the scoreboard and raises start for one cycle.
    task automatic applyStimulus(input int sym, input int nfft, input int cp, input logic [31:0] base);
        cfg_symbols = 8'(sym);
        cfg_nfft    = 16'(nfft);
        cfg_cp_len  = 16'(cp);
        frame_total = sym * (nfft + cp);
        data_base   = base;
        exp_q.delete();
        for (int i = 0; i < frame_total; i++) exp_q.push_back(base + 32'(i));
        beat_idx = 0; src_idx = 0; echo_pending = 0; echoed = 0;
        first_accept = -1; chain_low = 0; done_cnt = 0; done_cyc = -1;
        last_beat_cyc = -1; tvalid_seen = 0; err_at_done = 1'bx;
        s_axis_tdata = base;
        ddc_tvalid   = 1'b0;
        rel_cyc = 0;
        start   = 1'b1;
    endtask

    task automatic runUntilDone(input int budget, input bit inject_start);
        bit injected = 1'b0;
        for (int n = 0; n < budget && done_cnt == 0; n++) begin
            cycle();
            if (inject_start && !injected && beat_idx == 10) begin
                start    = 1'b1;
                injected = 1'b1;
            end
        end
        checkOutput("done_within_budget", (done_cnt > 0), 1'b1);
        repeat (5) cycle();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        aresetn = 1'b0; start = 1'b0;
        cfg_dac_fc = 32'd10737418; cfg_adc_fc = 32'd21474836;
        cfg_interp = 16'd40; cfg_decim = 16'd40;
        cfg_nfft = 16'd0; cfg_cp_len = 16'd0; cfg_symbols = 8'd0;
        s_axis_tdata = 32'h0; s_axis_tvalid = 1'b1; m_axis_tready = 1'b1;
        ddc_tvalid = 1'b0; ddc_tready = 1'b1;
        bp_mode = 1'b0; cfg_check = 1'b0; echo_limit = 1000;
        data_base = 32'h0; rel_cyc = 0; beat_idx = 0; src_idx = 0; echo_pending = 0; echoed = 0;
        frame_total = 0; done_cnt = 0;

        // Reset values
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        checkOutput("rst_chain_aresetn", chain_aresetn, 1'b0);
        checkOutput("rst_s_tready", s_axis_tready, 1'b0);
        checkOutput("rst_m_tvalid", m_axis_tvalid, 1'b0);
        checkOutput("rst_m_tlast", m_axis_tlast, 1'b0);
        checkOutput("rst_m_tkeep", m_axis_tkeep, 4'h0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_error", error, 1'b0);
        checkOutput("rst_dac_fc", DAC_Fc_scaled, 32'd0);
        checkOutput("rst_adc_fc", ADC_Fc_scaled, 32'd0);
        checkOutput("rst_interp", Interp_ratio, 16'd0);
        checkOutput("rst_decim", decimate_ratio, 16'd0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(negedge aclk);
        checkOutput("chain_before_edge", chain_aresetn, 1'b0);
        @(posedge aclk); #1;
        checkOutput("chain_after_edge", chain_aresetn, 1'b1);

        $display("[TB] basic frame with config and flush timing");
        cfg_check = 1'b1;
        applyStimulus(2, 16, 4, 32'hA000_0000);
        runUntilDone(400, 1'b0);
        cfg_check = 1'b0;
        checkOutput("basic_beats", beat_idx, frame_total);
        checkOutput("basic_queue_empty", exp_q.size(), 0);
        checkOutput("basic_done_pulses", done_cnt, 1);
        checkOutput("basic_error", err_at_done, 1'b0);
        checkOutput("basic_first_accept", first_accept, 66);
        checkOutput("basic_chain_low", chain_low, 64);
        checkOutput("basic_echoed", echoed, 40);
        checkOutput("basic_idle_busy", busy, 1'b0);

        $display("[TB] zero-length frame");
        applyStimulus(0, 16, 4, 32'hB000_0000);
        runUntilDone(20, 1'b0);
        checkOutput("zero_done_cycle", done_cyc, 2);
        checkOutput("zero_done_pulses", done_cnt, 1);
        checkOutput("zero_error", err_at_done, 1'b1);
        checkOutput("zero_no_tvalid", tvalid_seen, 0);
        checkOutput("zero_error_sticky", error, 1'b1);

        $display("[TB] backpressure frame with start during STREAM");
        bp_mode = 1'b1;
        applyStimulus(2, 16, 4, 32'hC000_0000);
        runUntilDone(600, 1'b1);
        bp_mode = 1'b0;
        checkOutput("bp_beats", beat_idx, frame_total);
        checkOutput("bp_src_consumed", src_idx, frame_total);
        checkOutput("bp_queue_empty", exp_q.size(), 0);
        checkOutput("bp_done_pulses", done_cnt, 1);
        checkOutput("bp_error_cleared", err_at_done, 1'b0);
        checkOutput("bp_start_ignored", busy, 1'b0);

        $display("[TB] reset mid-frame then clean frame");
        applyStimulus(2, 16, 4, 32'hD000_0000);
        for (int n = 0; n < 300 && beat_idx < 20; n++) cycle();
        checkOutput("mid_reached_beat20", beat_idx, 20);
        #2;
        aresetn = 1'b0;
        #1;
        checkOutput("mid_chain_aresetn", chain_aresetn, 1'b0);
        checkOutput("mid_m_tvalid", m_axis_tvalid, 1'b0);
        checkOutput("mid_s_tready", s_axis_tready, 1'b0);
        checkOutput("mid_m_tkeep", m_axis_tkeep, 4'h0);
        checkOutput("mid_busy", busy, 1'b0);
        checkOutput("mid_dac_fc", DAC_Fc_scaled, 32'd0);
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        ddc_tvalid = 1'b0;
        @(posedge aclk); #1;
        applyStimulus(2, 16, 4, 32'hE000_0000);
        runUntilDone(400, 1'b0);
        checkOutput("rerun_beats", beat_idx, frame_total);
        checkOutput("rerun_queue_empty", exp_q.size(), 0);
        checkOutput("rerun_done_pulses", done_cnt, 1);
        checkOutput("rerun_error", err_at_done, 1'b0);

`ifdef LOOPBACK_CTRL_TIMEOUT_EN
        $display("[TB] DRAIN timeout with 39 returned beats");
        echo_limit = 39;
        applyStimulus(2, 16, 4, 32'hF000_0000);
        runUntilDone(600, 1'b0);
        echo_limit = 1000;
        checkOutput("to_beats", beat_idx, frame_total);
        checkOutput("to_echoed", echoed, 39);
        checkOutput("to_error", err_at_done, 1'b1);
        checkOutput("to_done_pulses", done_cnt, 1);
        checkOutput("to_drain_length", done_cyc - last_beat_cyc, 102);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
